// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer
//
// Producer side of the engine's port-0 input FIFOs. Each burst fetches
// BURST_LEN/8 128-bit words for the data stream, then the same number for
// the weight stream. Every word is unpacked into eight 16-bit elements,
// lowest halfword first, and one element is pushed per cycle while the
// target FIFO is not full. Stream addresses carry over from one burst to
// the next, so the bursts of one command read contiguous memory.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    command strobe, accepted only in IDLE
//   op_num                   number of bursts, latched on start
//   data_addr, weight_addr   stream base word addresses, latched on start
//   busy                     command in progress
//   done                     one-cycle completion pulse
//   mem_rd_req/addr          read request, held until mem_rd_ack
//   mem_rd_ack               request accepted
//   mem_rd_valid/data        read return, one per accepted request
//   p0_data_fifo_*           data FIFO write port and full flag
//   p0_weight_fifo_*         weight FIFO write port and full flag
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// REQ_D  | data word request outstanding, waiting for ack
// WAIT_D | data request accepted, waiting for read data
// UNPK_D | pushing the 8 halfwords of a data word
// REQ_W  | weight word request outstanding, waiting for ack
// WAIT_W | weight request accepted, waiting for read data
// UNPK_W | pushing the 8 halfwords of a weight word
// DONE   | command finished, done pulse issued next cycle

module fifo_burst_writer #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 30,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       op_num,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [ADDR_W-1:0] weight_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [127:0]      mem_rd_data,
    output logic              p0_data_fifo_wr_en,
    output logic [15:0]       p0_data_fifo_din,
    input  logic              p0_data_fifo_full,
    output logic              p0_weight_fifo_wr_en,
    output logic [15:0]       p0_weight_fifo_din,
    input  logic              p0_weight_fifo_full
);

    localparam int                ECNT_W = $clog2(BURST_LEN + 1);
    localparam logic [ECNT_W-1:0] BL     = ECNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(ADDR_STEP);

    typedef enum logic [2:0] {
        IDLE,
        REQ_D,
        WAIT_D,
        UNPK_D,
        REQ_W,
        WAIT_W,
        UNPK_W,
        DONE
    } state_t;

    state_t            state;
    logic [31:0]       op_num_q;
    logic [31:0]       burst_cnt;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [127:0]      shift_q;
    logic [2:0]        hw_idx;
    logic [ECNT_W-1:0] elem_cnt;

    logic [ECNT_W-1:0] elem_nxt;
    logic              fifo_full;

    always_comb begin
        elem_nxt  = elem_cnt + 1'b1;
        fifo_full = (state == UNPK_W) ? p0_weight_fifo_full : p0_data_fifo_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            op_num_q             <= '0;
            burst_cnt            <= '0;
            d_addr               <= '0;
            w_addr               <= '0;
            shift_q              <= '0;
            hw_idx               <= '0;
            elem_cnt             <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            mem_rd_req           <= 1'b0;
            mem_rd_addr          <= '0;
            p0_data_fifo_wr_en   <= 1'b0;
            p0_data_fifo_din     <= '0;
            p0_weight_fifo_wr_en <= 1'b0;
            p0_weight_fifo_din   <= '0;
        end else begin
            done                 <= 1'b0;
            p0_data_fifo_wr_en   <= 1'b0;
            p0_weight_fifo_wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        op_num_q  <= op_num;
                        d_addr    <= data_addr;
                        w_addr    <= weight_addr;
                        burst_cnt <= '0;
                        elem_cnt  <= '0;
                        if (op_num == 32'd0) begin
                            state <= DONE;
                        end else begin
                            state       <= REQ_D;
                            busy        <= 1'b1;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= data_addr;
                        end
                    end
                end

                // The stream address is advanced on ack so that it already
                // points at the next word when the following request is built.
                REQ_D, REQ_W: begin
                    if (mem_rd_ack) begin
                        mem_rd_req <= 1'b0;
                        if (state == REQ_D) begin
                            d_addr <= d_addr + STEP;
                            state  <= WAIT_D;
                        end else begin
                            w_addr <= w_addr + STEP;
                            state  <= WAIT_W;
                        end
                    end
                end

                WAIT_D, WAIT_W: begin
                    if (mem_rd_valid) begin
                        shift_q <= mem_rd_data;
                        hw_idx  <= '0;
                        state   <= (state == WAIT_D) ? UNPK_D : UNPK_W;
                    end
                end

                UNPK_D, UNPK_W: begin
                    if (!fifo_full) begin
                        if (state == UNPK_D) begin
                            p0_data_fifo_wr_en <= 1'b1;
                            p0_data_fifo_din   <= shift_q[15:0];
                        end else begin
                            p0_weight_fifo_wr_en <= 1'b1;
                            p0_weight_fifo_din   <= shift_q[15:0];
                        end
                        shift_q  <= shift_q >> 16;
                        hw_idx   <= hw_idx + 3'd1;
                        elem_cnt <= elem_nxt;

                        if (hw_idx == 3'd7) begin
                            if (elem_nxt < BL) begin
                                // more words of the same stream in this burst
                                mem_rd_req <= 1'b1;
                                if (state == UNPK_D) begin
                                    state       <= REQ_D;
                                    mem_rd_addr <= d_addr;
                                end else begin
                                    state       <= REQ_W;
                                    mem_rd_addr <= w_addr;
                                end
                            end else if (state == UNPK_D) begin
                                elem_cnt    <= '0;
                                state       <= REQ_W;
                                mem_rd_req  <= 1'b1;
                                mem_rd_addr <= w_addr;
                            end else begin
                                elem_cnt  <= '0;
                                burst_cnt <= burst_cnt + 32'd1;
                                if ((burst_cnt + 32'd1) == op_num_q) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end else begin
                                    state       <= REQ_D;
                                    mem_rd_req  <= 1'b1;
                                    mem_rd_addr <= d_addr;
                                end
                            end
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
module tb_fifo_burst_writer;

    localparam int BURST_LEN = 16;
    localparam int ADDR_W    = 30;
    localparam int ADDR_STEP = 1;
    localparam int WPB       = BURST_LEN / 8;

    logic              clk         = 1'b0;
    logic              rst         = 1'b1;
    logic              start       = 1'b0;
    logic [31:0]       op_num      = '0;
    logic [ADDR_W-1:0] data_addr   = '0;
    logic [ADDR_W-1:0] weight_addr = '0;
    logic              busy;
    logic              done;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack   = 1'b0;
    logic              mem_rd_valid = 1'b0;
    logic [127:0]      mem_rd_data  = '0;
    logic              p0_data_fifo_wr_en;
    logic [15:0]       p0_data_fifo_din;
    logic              p0_data_fifo_full = 1'b0;
    logic              p0_weight_fifo_wr_en;
    logic [15:0]       p0_weight_fifo_din;
    logic              p0_weight_fifo_full = 1'b0;

    fifo_burst_writer #(
        .BURST_LEN(BURST_LEN),
        .ADDR_W   (ADDR_W),
        .ADDR_STEP(ADDR_STEP)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .op_num              (op_num),
        .data_addr           (data_addr),
        .weight_addr         (weight_addr),
        .busy                (busy),
        .done                (done),
        .mem_rd_req          (mem_rd_req),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_ack          (mem_rd_ack),
        .mem_rd_valid        (mem_rd_valid),
        .mem_rd_data         (mem_rd_data),
        .p0_data_fifo_wr_en  (p0_data_fifo_wr_en),
        .p0_data_fifo_din    (p0_data_fifo_din),
        .p0_data_fifo_full   (p0_data_fifo_full),
        .p0_weight_fifo_wr_en(p0_weight_fifo_wr_en),
        .p0_weight_fifo_din  (p0_weight_fifo_din),
        .p0_weight_fifo_full (p0_weight_fifo_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [15:0]       exp_d[$];
    logic [15:0]       exp_w[$];
    int ops_pending = 0;
    int done_cnt    = 0;
    int wr_d_cnt    = 0;
    int wr_w_cnt    = 0;
    int inj_req     = 0;
    int inj_done    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed function of word address and halfword index.
    function automatic logic [15:0] hw_of(input logic [ADDR_W-1:0] a, input int i);
        return 16'(32'(a) * 8 + i) ^ 16'h3C5A;
    endfunction

    function automatic logic [127:0] word_of(input logic [ADDR_W-1:0] a);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[16*i +: 16] = hw_of(a, i);
        return w;
    endfunction

    // Reference: burst k reads WPB data words from da + k*WPB*STEP, then WPB
    // weight words from wa + k*WPB*STEP; every word yields 8 elements, low first.
    task automatic model_op(input int unsigned n, input logic [ADDR_W-1:0] da,
                            input logic [ADDR_W-1:0] wa);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < int'(n); k++) begin
            for (int j = 0; j < WPB; j++) begin
                a = ADDR_W'(32'(da) + (k * WPB + j) * ADDR_STEP);
                exp_addr.push_back(a);
                for (int i = 0; i < 8; i++) exp_d.push_back(hw_of(a, i));
            end
            for (int j = 0; j < WPB; j++) begin
                a = ADDR_W'(32'(wa) + (k * WPB + j) * ADDR_STEP);
                exp_addr.push_back(a);
                for (int i = 0; i < 8; i++) exp_w.push_back(hw_of(a, i));
            end
        end
        ops_pending++;
    endtask

    // Memory responder and request-side monitor.
    int                req_wait = 0;
    int                ack_tgt  = 0;
    int                vdelay   = 0;
    bit                outst    = 0;
    bit                req_prev = 0;
    logic [ADDR_W-1:0] acked_addr = '0;
    logic [ADDR_W-1:0] held_addr  = '0;

    always @(negedge clk) begin
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        if (rst) begin
            outst    = 0;
            req_wait = 0;
            req_prev = 0;
        end else begin
            if (inj_req != inj_done) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = word_of(ADDR_W'(32'h155));
                inj_done++;
            end else if (outst) begin
                if (vdelay == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = word_of(acked_addr);
                    outst        = 0;
                end else begin
                    vdelay--;
                end
            end
            if (mem_rd_req && !outst) begin
                if (req_prev) check("req_addr_stable", mem_rd_addr, held_addr);
                held_addr = mem_rd_addr;
                if (req_wait >= ack_tgt) begin
                    mem_rd_ack = 1'b1;
                    outst      = 1;
                    vdelay     = $urandom_range(0, 2);
                    acked_addr = mem_rd_addr;
                    if (exp_addr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %0h expected no request", mem_rd_addr);
                    end else begin
                        check("req_addr", mem_rd_addr, exp_addr.pop_front());
                    end
                    req_wait = 0;
                    ack_tgt  = $urandom_range(0, 5);
                    req_prev = 0;
                end else begin
                    req_wait++;
                    req_prev = 1;
                end
            end else begin
                req_prev = 0;
            end
        end
    end

    always @(negedge clk) begin
        p0_data_fifo_full   = ($urandom_range(0, 3) == 0);
        p0_weight_fifo_full = ($urandom_range(0, 3) == 0);
    end

    // FIFO-side and completion monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (p0_data_fifo_wr_en) begin
                wr_d_cnt++;
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_write: got %0h expected none", p0_data_fifo_din);
                end else begin
                    check("data_din", p0_data_fifo_din, exp_d.pop_front());
                end
            end
            if (p0_weight_fifo_wr_en) begin
                wr_w_cnt++;
                if (exp_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_weight_write: got %0h expected none", p0_weight_fifo_din);
                end else begin
                    check("weight_din", p0_weight_fifo_din, exp_w.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 1'b0);
                if (ops_pending == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    check("drained_at_done", exp_addr.size() + exp_d.size() + exp_w.size(), 0);
                    ops_pending--;
                end
            end
        end
    end

    task automatic chk_outputs_zero();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", mem_rd_req, 1'b0);
        check("rst_addr", mem_rd_addr, '0);
        check("rst_d_wr_en", p0_data_fifo_wr_en, 1'b0);
        check("rst_d_din", p0_data_fifo_din, '0);
        check("rst_w_wr_en", p0_weight_fifo_wr_en, 1'b0);
        check("rst_w_din", p0_weight_fifo_din, '0);
    endtask

    task automatic do_op(input int unsigned n, input logic [ADDR_W-1:0] da,
                         input logic [ADDR_W-1:0] wa, input bit poke);
        int cyc;
        int d0;
        d0 = done_cnt;
        @(negedge clk); #1;
        start       = 1'b1;
        op_num      = n;
        data_addr   = da;
        weight_addr = wa;
        model_op(n, da, wa);
        @(negedge clk); #1;
        start       = 1'b0;
        op_num      = $urandom;
        data_addr   = ADDR_W'($urandom);
        weight_addr = ADDR_W'($urandom);
        check("busy_after_start", busy, (n != 0));
        if (n == 0) begin
            check("zero_op_done_early", done, 1'b0);
            @(negedge clk); #1;
            check("zero_op_done", done, 1'b1);
            check("zero_op_busy", busy, 1'b0);
        end else if (poke) begin
            repeat (3) @(negedge clk);
            #1;
            check("busy_before_poke", busy, 1'b1);
            start       = 1'b1;
            op_num      = 32'd5;
            data_addr   = ADDR_W'(32'h3AB);
            weight_addr = ADDR_W'(32'h7CD);
            @(negedge clk); #1;
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 4000) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("done_count", done_cnt - d0, 1);
        @(negedge clk); #1;
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        int cyc;
        int d0;
        int w0;

        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero();
        rst = 1'b0;

        do_op(1, ADDR_W'(32'h100), ADDR_W'(32'h200), 0);
        do_op(3, ADDR_W'(32'h100), ADDR_W'(32'h200), 1);
        do_op(0, ADDR_W'(32'h100), ADDR_W'(32'h200), 0);
        for (int r = 0; r < 8; r++)
            do_op($urandom_range(1, 4), ADDR_W'($urandom), ADDR_W'($urandom), bit'($urandom_range(0, 1)));
        do_op(2, ADDR_W'(32'h3FFF_FFFE), ADDR_W'(32'h3FFF_FFFF), 0);

        // abort in the middle of the second data word
        d0 = wr_d_cnt;
        @(negedge clk); #1;
        start       = 1'b1;
        op_num      = 32'd2;
        data_addr   = ADDR_W'(32'h500);
        weight_addr = ADDR_W'(32'h600);
        model_op(2, ADDR_W'(32'h500), ADDR_W'(32'h600));
        @(negedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while ((wr_d_cnt - d0) < 10 && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("reached_second_word", ((wr_d_cnt - d0) >= 10), 1'b1);
        rst = 1'b1;
        #1;
        chk_outputs_zero();
        exp_addr.delete();
        exp_d.delete();
        exp_w.delete();
        ops_pending = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        d0 = wr_d_cnt;
        w0 = wr_w_cnt;
        inj_req++;
        repeat (6) @(negedge clk);
        #1;
        check("no_write_after_reset", (wr_d_cnt - d0) + (wr_w_cnt - w0), 0);
        check("no_req_after_reset", mem_rd_req, 1'b0);
        check("no_busy_after_reset", busy, 1'b0);
        do_op(1, ADDR_W'(32'h700), ADDR_W'(32'h800), 0);

        check("final_queues_empty", exp_addr.size() + exp_d.size() + exp_w.size(), 0);
        check("final_ops_pending", ops_pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
